// File: rtl/mem_ctrl_pkg.sv
// Shared memory-stage definitions: bus widths, load/store opcodes and the
// decoded request record used by the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ALUOP_W     = 8;
  localparam int DATA_ADDR_W = 32;

  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b11101011;

  // last holds the index of the final byte (size - 1)
  typedef struct packed {
    logic       req;
    logic       load;
    logic [1:0] last;
  } mem_op_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Memory-stage request/response bus plus the byte-wide synchronous RAM port.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DATA_ADDR_W,
  parameter int RAM_AW = 17
);

  logic [ADDR_W-1:0]  mem_addr_i;
  logic [ALUOP_W-1:0] mem_aluop_i;
  logic [31:0]        rt_data_i;
  logic               stall_i;
  logic               done_o;
  logic [31:0]        rdata_o;
  logic [RAM_AW-1:0]  ram_addr_o;
  logic [7:0]         ram_dout_o;
  logic               ram_we_o;
  logic [7:0]         ram_din_i;

  modport slave (
    input  mem_addr_i, mem_aluop_i, rt_data_i, stall_i, ram_din_i,
    output done_o, rdata_o, ram_addr_o, ram_dout_o, ram_we_o
  );

  modport master (
    output mem_addr_i, mem_aluop_i, rt_data_i, stall_i, ram_din_i,
    input  done_o, rdata_o, ram_addr_o, ram_dout_o, ram_we_o
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial load/store controller: splits LB/LH/LW/SB/SH/SW into one RAM
// byte per cycle and raises done_o until the memory stage advances.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DATA_ADDR_W,
  parameter int RAM_AW = 17
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  function automatic mem_op_t decode(input logic [ALUOP_W-1:0] op);
    mem_op_t d;
    d = '0;
    case (op)
      EXE_LB_OP, EXE_LBU_OP: d = '{req: 1'b1, load: 1'b1, last: 2'd0};
      EXE_LH_OP, EXE_LHU_OP: d = '{req: 1'b1, load: 1'b1, last: 2'd1};
      EXE_LW_OP:             d = '{req: 1'b1, load: 1'b1, last: 2'd3};
      EXE_SB_OP:             d = '{req: 1'b1, load: 1'b0, last: 2'd0};
      EXE_SH_OP:             d = '{req: 1'b1, load: 1'b0, last: 2'd1};
      EXE_SW_OP:             d = '{req: 1'b1, load: 1'b0, last: 2'd3};
      default:               d = '0;
    endcase
    return d;
  endfunction

  state_t            state_q, state_d;
  mem_op_t           op_in;
  logic              load_q, load_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        nidx, pidx;
  logic [RAM_AW-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_we_q, ram_we_d;
  logic              unused_addr_hi;

  // Address bits above the RAM window are dropped, giving modulo-2^RAM_AW wrap
  assign unused_addr_hi = ^bus.mem_addr_i[ADDR_W-1:RAM_AW];

  assign op_in = decode(bus.mem_aluop_i);
  assign nidx  = idx_q + 2'd1;
  assign pidx  = idx_q - 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_in.req) state_d = ACCESS;
      ACCESS:  if (idx_q == last_q) state_d = load_q ? CAPTURE : DONE;
      CAPTURE: state_d = DONE;
      DONE:    if (!bus.stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output; RAM read data lags its address by one cycle
  always_comb begin
    load_d     = load_q;
    last_d     = last_q;
    idx_d      = idx_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    ram_we_d   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_in.req) begin
          load_d     = op_in.load;
          last_d     = op_in.last;
          idx_d      = 2'd0;
          base_d     = bus.mem_addr_i[RAM_AW-1:0];
          wdata_d    = bus.rt_data_i;
          rdata_d    = '0;
          ram_addr_d = bus.mem_addr_i[RAM_AW-1:0];
          ram_dout_d = bus.rt_data_i[7:0];
          ram_we_d   = !op_in.load;
        end
      end
      ACCESS: begin
        if (load_q && (idx_q != 2'd0)) rdata_d[{pidx, 3'b000} +: 8] = bus.ram_din_i;
        if (idx_q != last_q) begin
          idx_d      = nidx;
          ram_addr_d = base_q + RAM_AW'(nidx);
          ram_dout_d = wdata_q[{nidx, 3'b000} +: 8];
          ram_we_d   = !load_q;
        end else begin
          done_d = !load_q;
        end
      end
      CAPTURE: begin
        rdata_d[{idx_q, 3'b000} +: 8] = bus.ram_din_i;
        done_d = 1'b1;
      end
      DONE:    done_d = bus.stall_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_q     <= 1'b0;
      last_q     <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_dout_q <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      load_q     <= load_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign bus.done_o     = done_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.ram_addr_o = ram_addr_q;
  assign bus.ram_dout_o = ram_dout_q;
  assign bus.ram_we_o   = ram_we_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed loads/stores against a byte RAM model,
// with completion and RAM-write monitors popping expected-value queues.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam logic [7:0] NOP = 8'h00;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    int          done_cyc;
  } done_t;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  done_t       dq[$];
  wr_t         wq[$];
  logic [7:0]  mem [0:(1<<17)-1];
  logic        bk_we;
  logic [16:0] bk_addr;
  logic [7:0]  bk_data;
  logic        done_prev = 1'b0;

  mem_ctrl_if #(.ADDR_W(32), .RAM_AW(17)) bus ();

  mem_ctrl #(.ADDR_W(32), .RAM_AW(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with one-cycle read latency; bk_* preloads contents
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_dout_o;
    bus.ram_din_i <= mem[bus.ram_addr_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin
    done_t e;
    if (bus.done_o && !done_prev) begin
      if (dq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = dq.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("we_in_done", {31'd0, bus.ram_we_o}, 32'd0);
        if (e.is_load) check("load_rdata", bus.rdata_o, e.rdata);
      end
    end
    done_prev = bus.done_o;
  end

  // RAM write monitor
  always @(negedge clk) begin
    wr_t w;
    if (bus.ram_we_o) begin
      if (wq.size() == 0) begin
        check("unexpected_write", {15'd0, bus.ram_addr_o}, 32'hFFFF_FFFF);
      end else begin
        w = wq.pop_front();
        check("wr_addr", {15'd0, bus.ram_addr_o}, {15'd0, w.addr});
        check("wr_data", {24'd0, bus.ram_dout_o}, {24'd0, w.data});
      end
    end
  end

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    bk_we = 1'b1;
    bk_addr = a;
    bk_data = d;
  endtask

  // Called at a negedge; returns the cycle number seen just after the accepting edge
  task automatic issue(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] data, output int acc);
    bus.mem_aluop_i = op;
    bus.mem_addr_i  = addr;
    bus.rt_data_i   = data;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.mem_aluop_i = NOP;
    bus.mem_addr_i  = 32'hFFFF_FFFF;
    bus.rt_data_i   = 32'h0BAD_F00D;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done_o) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic is_load, input logic [31:0] exp, input int nbytes);
    int a;
    if (!is_load)
      for (int k = 0; k < nbytes; k++) wq.push_back('{17'(addr + k), data[8*k +: 8]});
    issue(op, addr, data, a);
    dq.push_back('{is_load, exp, a + nbytes + (is_load ? 2 : 1) - 1});
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int a;
    logic [31:0] held_rdata;
    logic [16:0] held_addr;
    rst = 1'b0;
    bk_we = 1'b0;
    bk_addr = '0;
    bk_data = '0;
    bus.mem_aluop_i = NOP;
    bus.mem_addr_i = '0;
    bus.rt_data_i = '0;
    bus.stall_i = 1'b0;
    repeat (2) @(negedge clk);
    poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
    poke(17'h204, 8'h5A); poke(17'h007, 8'h80);
    poke(17'h300, 8'hCD); poke(17'h301, 8'hAB); poke(17'h302, 8'h77);
    poke(17'h1FFFE, 8'hA1); poke(17'h1FFFF, 8'hB2); poke(17'h00000, 8'hC3); poke(17'h00001, 8'hD4);
    poke(17'h402, 8'h99);
    @(negedge clk);
    bk_we = 1'b0;

    check("rst_done",     {31'd0, bus.done_o}, 32'd0);
    check("rst_rdata",    bus.rdata_o, 32'd0);
    check("rst_ram_addr", {15'd0, bus.ram_addr_o}, 32'd0);
    check("rst_ram_dout", {24'd0, bus.ram_dout_o}, 32'd0);
    check("rst_ram_we",   {31'd0, bus.ram_we_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(EXE_LW_OP,  32'h0000_0100, 32'h0, 1'b1, 32'h4433_2211, 4);
    run_op(EXE_SH_OP,  32'h0000_0202, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
    run_op(EXE_LB_OP,  32'h0000_0007, 32'h0, 1'b1, 32'h0000_0080, 1);
    run_op(EXE_LHU_OP, 32'h0000_0300, 32'h0, 1'b1, 32'h0000_ABCD, 2);
    run_op(EXE_LH_OP,  32'h0000_0301, 32'h0, 1'b1, 32'h0000_77AB, 2);
    run_op(EXE_SB_OP,  32'h0000_0010, 32'h1234_56A5, 1'b0, 32'h0, 1);
    run_op(EXE_LW_OP,  32'h0001_FFFE, 32'h0, 1'b1, 32'hD4C3_B2A1, 4);
    run_op(EXE_LBU_OP, 32'hFFFE_0100, 32'h0, 1'b1, 32'h0000_0011, 1);

    // LW then hold the stage for three cycles in DONE
    issue(EXE_LW_OP, 32'h0000_0100, 32'h0, a);
    dq.push_back('{1'b1, 32'h4433_2211, a + 5});
    wait_done();
    bus.stall_i = 1'b1;
    held_rdata = bus.rdata_o;
    held_addr = bus.ram_addr_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_done", {31'd0, bus.done_o}, 32'd1);
      check("stall_rdata", bus.rdata_o, held_rdata);
      check("stall_addr", {15'd0, bus.ram_addr_o}, {15'd0, held_addr});
    end
    bus.stall_i = 1'b0;
    @(negedge clk);
    check("stall_release", {31'd0, bus.done_o}, 32'd0);

    // SB held on the bus: the DONE-exit edge must not accept it
    wq.push_back('{17'h20, 8'h3C});
    wq.push_back('{17'h20, 8'h3C});
    bus.mem_aluop_i = EXE_SB_OP;
    bus.mem_addr_i = 32'h20;
    bus.rt_data_i = 32'h0000_003C;
    @(posedge clk);
    #1;
    dq.push_back('{1'b0, 32'h0, cyc + 1});
    repeat (3) @(posedge clk);
    #1;
    dq.push_back('{1'b0, 32'h0, cyc + 1});
    bus.mem_aluop_i = NOP;
    wait_done();
    @(negedge clk);

    // SW aborted by reset after its second write cycle
    wq.push_back('{17'h400, 8'h21});
    wq.push_back('{17'h401, 8'h43});
    issue(EXE_SW_OP, 32'h0000_0400, 32'h8765_4321, a);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_we", {31'd0, bus.ram_we_o}, 32'd0);
    check("abort_done", {31'd0, bus.done_o}, 32'd0);
    check("abort_addr", {15'd0, bus.ram_addr_o}, 32'd0);
    @(negedge clk);
    check("abort_done2", {31'd0, bus.done_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_op(EXE_LB_OP, 32'h0000_0400, 32'h0, 1'b1, 32'h0000_0021, 1);
    run_op(EXE_LB_OP, 32'h0000_0402, 32'h0, 1'b1, 32'h0000_0099, 1);

    repeat (3) @(negedge clk);
    check("ram_202", {24'd0, mem[17'h202]}, 32'hEF);
    check("ram_203", {24'd0, mem[17'h203]}, 32'hBE);
    check("ram_204", {24'd0, mem[17'h204]}, 32'h5A);
    check("ram_010", {24'd0, mem[17'h010]}, 32'hA5);
    check("ram_401", {24'd0, mem[17'h401]}, 32'h43);
    check("done_queue_empty", dq.size(), 32'd0);
    check("write_queue_empty", wq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
